// File: rtl/excess3_pkg.sv
// Shared types and constants for the excess-3 receive path.
// Optional range check enabled by EXCESS3_DEC_ERRCHK_EN.
package excess3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] E3_BIAS     = 4'd3;
  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam logic [3:0] E3_ERR_CODE = 4'hF;

endpackage

// File: rtl/e3_sub_bit.sv
// One-bit full subtractor: d = e - k - b_in, with borrow out.
// Reused on every SHIFT cycle of the decoder.
module e3_sub_bit (
  input  logic e,
  input  logic k,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  assign d     = e ^ k ^ b_in;
  assign b_out = (~e & k) | (~e & b_in) | (k & b_in);

endmodule

// File: rtl/excess3_decoder.sv
// Bit-serial excess-3 to BCD decoder, one subtract bit per clock.
// Define EXCESS3_DEC_ERRCHK_EN to flag and replace illegal codes.
module excess3_decoder (
  input  logic       the_clock,
  input  logic       the_reset,
  input  logic [3:0] e3_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] bcd_out,
  output logic       out_valid,
  output logic       out_error
);

  import excess3_pkg::*;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_sr;
  logic [3:0] r_res;
  logic [3:0] r_bcd;
  logic [1:0] r_cnt;
  logic       r_b;

  logic       w_accept;
  logic       w_last;
  logic       w_e;
  logic       w_k;
  logic       w_d;
  logic       w_bo;
  logic [3:0] w_raw;
  logic [3:0] w_bcd_nx;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_state == SHIFT) && (r_cnt == 2'd3);
  assign w_e      = r_sr[r_cnt];
  assign w_k      = E3_BIAS[r_cnt];
  assign w_raw    = {w_d, r_res[2:0]};

  e3_sub_bit u_sub (
    .e     (w_e),
    .k     (w_k),
    .b_in  (r_b),
    .d     (w_d),
    .b_out (w_bo)
  );

  always_ff @(posedge the_clock) begin
    if (the_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_next = SHIFT;
      end
      SHIFT: begin
        if (r_cnt == 2'd3) w_next = DONE;
      end
      DONE: begin
        w_next = w_accept ? SHIFT : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state != SHIFT);
    out_valid = (r_state == DONE);
  end

  // Accept can only happen outside SHIFT, so it never races a shift step.
  always_ff @(posedge the_clock) begin
    if (the_reset) begin
      r_sr  <= 4'd0;
      r_res <= 4'd0;
      r_bcd <= 4'd0;
      r_cnt <= 2'd0;
      r_b   <= 1'b0;
    end else if (w_accept) begin
      r_sr  <= e3_in;
      r_b   <= 1'b0;
      r_cnt <= 2'd0;
    end else if (r_state == SHIFT) begin
      r_res[r_cnt] <= w_d;
      r_b          <= w_bo;
      r_cnt        <= r_cnt + 2'd1;
      if (w_last) r_bcd <= w_bcd_nx;
    end
  end

  assign bcd_out = r_bcd;

`ifdef EXCESS3_DEC_ERRCHK_EN
  logic w_err;
  logic r_err;

  // Final borrow marks codes below the bias; the compare catches 13..15.
  assign w_err    = w_bo | (w_raw > BCD_MAX);
  assign w_bcd_nx = w_err ? E3_ERR_CODE : w_raw;

  always_ff @(posedge the_clock) begin
    if (the_reset) begin
      r_err <= 1'b0;
    end else if (w_last) begin
      r_err <= w_err;
    end
  end

  assign out_error = r_err;
`else
  assign w_bcd_nx  = w_raw;
  assign out_error = 1'b0;
`endif

endmodule

// File: tb/tb_excess3_decoder.sv
// Self-checking bench for excess3_decoder.
// Expectations follow EXCESS3_DEC_ERRCHK_EN when defined.
module tb_excess3_decoder;

  logic       clk;
  logic       rst;
  logic [3:0] e3_in;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] bcd_out;
  logic       out_valid;
  logic       out_error;

  int checks;
  int errors;

  excess3_decoder dut (
    .the_clock (clk),
    .the_reset (rst),
    .e3_in     (e3_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_out   (bcd_out),
    .out_valid (out_valid),
    .out_error (out_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: subtract the bias arithmetically, flag codes outside 3..12.
  function automatic logic [4:0] model(input int code);
    int         diff;
    logic [3:0] v;
    diff = code - 3;
    if (diff < 0) diff = diff + 16;
    v = 4'(diff);
`ifdef EXCESS3_DEC_ERRCHK_EN
    if (code < 3 || code > 12) return {1'b1, 4'hF};
`endif
    return {1'b0, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction from IDLE, checking latency and result.
  task automatic send(input string tag, input int code);
    logic [4:0] exp;
    int         lat;
    exp = model(code);
    chk({tag, "_ready"}, 8'(in_ready), 8'd1);
    e3_in    = 4'(code);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, 8'(in_ready), 8'd0);
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      e3_in = 4'($urandom);
      tick();
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_lat"}, 8'(lat), 8'd4);
    chk({tag, "_bcd"}, 8'(bcd_out), 8'(exp[3:0]));
    chk({tag, "_err"}, 8'(out_error), 8'(exp[4]));
    tick();
    chk({tag, "_strobe1"}, 8'(out_valid), 8'd0);
    chk({tag, "_hold"}, 8'(bcd_out), 8'(exp[3:0]));
  endtask

  initial begin
    int         t1;
    int         t2;
    int         code;
    logic       seen;
    logic [4:0] exp;
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    e3_in    = 4'd0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_ready", 8'(in_ready), 8'd1);
    chk("rst_bcd", 8'(bcd_out), 8'd0);
    chk("rst_valid", 8'(out_valid), 8'd0);
    chk("rst_err", 8'(out_error), 8'd0);

    for (int c = 3; c <= 12; c++) send($sformatf("legal%0d", c), c);

    send("low1", 1);
    send("high14", 14);
    send("zero", 0);
    send("top15", 15);

    // Back-to-back: second word offered in the DONE cycle.
    e3_in    = 4'd7;
    in_valid = 1'b1;
    tick();
    t1 = 0;
    t2 = 0;
    for (int i = 1; i <= 20; i++) begin
      e3_in = 4'($urandom);
      if (t1 != 0) e3_in = (i == t1 + 1) ? 4'($urandom) : e3_in;
      tick();
      if (out_valid && t1 == 0) begin
        t1 = i;
        chk("b2b_first", 8'(bcd_out), 8'd4);
        e3_in = 4'd10;
        tick();
        i++;
      end else if (out_valid) begin
        t2 = i;
        in_valid = 1'b0;
        chk("b2b_second", 8'(bcd_out), 8'd7);
        break;
      end
    end
    chk("b2b_first_lat", 8'(t1), 8'd4);
    chk("b2b_gap", 8'(t2 - t1), 8'd5);
    tick();
    chk("b2b_idle", 8'(in_ready), 8'd1);
    chk("b2b_nostrobe", 8'(out_valid), 8'd0);

    // Reset on the second SHIFT cycle discards the word.
    e3_in    = 4'd8;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_bcd", 8'(bcd_out), 8'd0);
    chk("midrst_ready", 8'(in_ready), 8'd1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | out_valid;
    end
    chk("midrst_nostrobe", 8'(seen), 8'd0);
    send("after_rst", 4);

    // Reset coinciding with an offered word wins.
    e3_in    = 4'd5;
    in_valid = 1'b1;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    seen     = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | out_valid;
    end
    chk("rstacc_nostrobe", 8'(seen), 8'd0);
    chk("rstacc_bcd", 8'(bcd_out), 8'd0);

    // Loopback with an encoder model: digit + 3 must decode to digit.
    for (int d = 0; d <= 9; d++) begin
      send($sformatf("loop%0d", d), d + 3);
      chk($sformatf("loop%0d_id", d), 8'(bcd_out), 8'(d));
    end

    // Random codes against the arithmetic reference.
    for (int n = 0; n < 24; n++) begin
      code = int'($urandom_range(0, 15));
      exp  = model(code);
      send($sformatf("rnd%0d_c%0d", n, code), code);
      chk($sformatf("rnd%0d_final", n), 8'(bcd_out), 8'(exp[3:0]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
